kbd_scan_4x4: RTL and testbench
===============================

# kbd_scan_4x4

Scanner for a 4x4 matrix keypad. It is the input-side counterpart of the multiplexed 7-segment display driver: it scans columns instead of anodes and reads rows instead of driving segments. It debounces key presses and emits one hex code per accepted press. It shifts the accepted digits into a 16-bit value that the top level routes to the display's `cnt_val_*_i` inputs.

## Interface
Reset: one clock; reset is asynchronous and active-high.

Parameters:
- `SCAN_DIV`, default 100_000: clock cycles per column step (1 kHz step rate, 250 Hz frame rate).
- `DEB_FRAMES`, default 3: consecutive identical frames required to accept a press, and consecutive empty frames required to accept a release. Legal range 1..15.

Ports:
- `clk_100MHz_i`, in, 1: system clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `row_i`, in, 4: keypad rows, active-low, asynchronous to the clock, externally pulled up.
- `col_o`, out, 4: column drive, active-low, exactly one bit low at any time.
- `clr_i`, in, 1: synchronous clear of `val_o`.
- `key_valid_o`, out, 1: one-cycle pulse per accepted press.
- `key_code_o`, out, 4: code of the last accepted key.
- `val_o`, out, 16: digit shift register. Newest digit sits in [3:0].

## Operation
- **Row synchronizer:** `row_i` passes through a 2-FF synchronizer. All logic uses only the synchronized rows.
- **Divider:** counts 0..SCAN_DIV-1 and wraps. The step pulse fires at SCAN_DIV-1.
- **Column index:** `col_idx` (2 bits) increments on each step and wraps 3 -> 0. `col_o = ~(4'b0001 << col_idx)`.
- **Row sampling:** on each step pulse, before the column advances, the synchronized rows are sampled for the current column.
  - Each low row bit counts as one pressed key.
  - The per-frame accumulator records the key count, saturating at 2, and the code of the first key found.
- **Frame end:** a frame ends on the step with `col_idx==3`. Each frame is classified as one of:
  - NONE: zero keys.
  - SINGLE(code): exactly one key.
  - MULTI: two or more keys. MULTI is treated as NONE for press detection and as not-empty for release detection.
- **Key map** (row r, col c -> code):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: E 0 F D
- **FSM:** states IDLE, DEBOUNCE, HELD. It is evaluated only at frame end.
  - **IDLE:**
    - SINGLE(k): set cand=k, deb_cnt=1, go to DEBOUNCE. If DEB_FRAMES==1, accept immediately and go to HELD.
    - Otherwise: stay in IDLE.
  - **DEBOUNCE:**
    - SINGLE(cand): increment deb_cnt. When deb_cnt reaches DEB_FRAMES, accept and go to HELD.
    - Any other frame: go to IDLE. No output change.
  - **HELD:**
    - NONE frame: increment rel_cnt. When rel_cnt reaches DEB_FRAMES, go to IDLE.
    - SINGLE or MULTI frame: clear rel_cnt.
    - There is no auto-repeat.
- **Accept:** `key_valid_o`=1 for one cycle, `key_code_o`=cand, `val_o = {val_o[11:0], cand}`.
- **Clear:** `clr_i` sets `val_o`=0 on the next edge. If it coincides with an accept, clear wins and the digit is dropped. `key_valid_o` and `key_code_o` still update.

## Timing
- Reset values:
  - `col_o`=4'b1110
  - `key_valid_o`=0
  - `key_code_o`=0
  - `val_o`=0
  - FSM=IDLE; divider, `col_idx`, accumulator and debounce counters all 0.
- Reset applied mid-debounce or mid-hold discards all state with no pulse. Scanning restarts at column 0.
- `key_valid_o`, `key_code_o` and `val_o` are registered. They update one cycle after the frame-end step pulse.
- Row settling time before sampling is SCAN_DIV-1 cycles. Synchronizer latency is 2 cycles.
- Press-to-pulse latency: the first clean frame plus DEB_FRAMES-1 further frames, plus 1 cycle.
- Minimum gap between two accepts: DEB_FRAMES empty frames (release) plus DEB_FRAMES frames (press).

## Structure
- Package `kbd_pkg` holds:
  - the `kbd_state_t` enum (IDLE, DEBOUNCE, HELD)
  - the 16-entry key-map constant, indexed {row, col}
  - `KBD_ROWS` / `KBD_COLS` = 4
- Sub-module `sync_2ff` (parameterized width) holds the row synchronizer.
- The divider, accumulator, FSM and shift register stay in the top module.

## Test plan
All scenarios use bench parameters SCAN_DIV=4 and DEB_FRAMES=3 (16-cycle frames).
1. Reset: assert `rst` asynchronously mid-cycle -> `col_o`=1110, `val_o`=0x0000 and `key_valid_o`=0 immediately. Then `col_o` steps 1101, 1011, 0111 every 4 cycles.
2. Hold key r1c2 for 6 frames, then release for 4 frames -> exactly one `key_valid_o` pulse, `key_code_o`=6, `val_o`=0x0006, no repeat.
3. Press and release 1, 2, 3, A, 4 in sequence, 5 frames each with 4-frame gaps -> five pulses, final `val_o`=0x23A4.
4. Bounce: r2c0 down for 2 frames, up for 1, down for 2 -> no pulse, `val_o` unchanged.
5. Keys r0c0 and r0c1 held together for 6 frames -> no pulse. Release r0c1 -> key 1 is accepted after 3 single frames.
6. `clr_i` asserted on the accept cycle of key 9 with `val_o`=0x1234 -> `val_o`=0x0000, pulse present, `key_code_o`=9. Separately, `rst` asserted during DEBOUNCE -> no pulse afterwards without a fresh 3-frame press.

Source files
------------

// File: rtl/kbd_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package kbd_pkg;

  localparam int KBD_ROWS = 4;
  localparam int KBD_COLS = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } kbd_state_t;

  // Key code per switch, indexed {row[1:0], col[1:0]}; entry 0 is row 0 / col 0.
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; reset value is a parameter
// so idle pulled-up lines come out of reset as "inactive".
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/kbd_scan_4x4.sv
// 4x4 keypad scanner: column scan, per-frame classification, press/release
// debounce FSM and a 4-digit shift register of accepted key codes.
module kbd_scan_4x4
  import kbd_pkg::*;
#(
  parameter int SCAN_DIV   = 100_000,
  parameter int DEB_FRAMES = 3
) (
  input  logic        clk_100MHz_i,
  input  logic        rst,
  input  logic [3:0]  row_i,
  output logic [3:0]  col_o,
  input  logic        clr_i,
  output logic        key_valid_o,
  output logic [3:0]  key_code_o,
  output logic [15:0] val_o
);

  localparam int               DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]       DEB_LAST = 4'(DEB_FRAMES);

  logic [3:0]       row_s;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic             step;
  logic             frame_end;

  logic [1:0]       acc_cnt_q, acc_cnt_d;
  logic [3:0]       acc_code_q, acc_code_d;
  logic [2:0]       col_cnt;
  logic [1:0]       first_row;
  logic             found;
  logic [2:0]       cnt_sum;
  logic [1:0]       frame_cnt;
  logic [3:0]       frame_code;

  kbd_state_t       state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [3:0]       deb_cnt_q, deb_cnt_d;
  logic [3:0]       rel_cnt_q, rel_cnt_d;
  logic             accept;
  logic [3:0]       accept_code;

  logic             key_valid_q, key_valid_d;
  logic [3:0]       key_code_q, key_code_d;
  logic [15:0]      val_q, val_d;

  // Rows idle high (pulled up), so the synchronizer resets to "no key".
  sync_2ff #(
    .WIDTH   (KBD_ROWS),
    .RST_VAL (4'hF)
  ) u_row_sync (
    .clk_i (clk_100MHz_i),
    .rst_i (rst),
    .d_i   (row_i),
    .q_o   (row_s)
  );

  assign step      = (div_q == DIV_LAST);
  assign frame_end = step && (col_idx_q == 2'(KBD_COLS - 1));
  assign col_o     = ~(4'b0001 << col_idx_q);

  // Count low rows in the driven column; the lowest low row is the first key found.
  always_comb begin
    col_cnt   = '0;
    first_row = '0;
    found     = 1'b0;
    for (int r = 0; r < KBD_ROWS; r++) begin
      if (!row_s[r]) begin
        col_cnt = col_cnt + 3'd1;
        if (!found) begin
          first_row = 2'(r);
          found     = 1'b1;
        end
      end
    end
  end

  assign cnt_sum    = {1'b0, acc_cnt_q} + col_cnt;
  assign frame_cnt  = (cnt_sum >= 3'd2) ? 2'd2 : cnt_sum[1:0];
  assign frame_code = (acc_cnt_q == 2'd0 && found) ? KEY_MAP[{first_row, col_idx_q}]
                                                   : acc_code_q;

  always_comb begin
    div_d      = step ? '0 : div_q + 1'b1;
    col_idx_d  = step ? col_idx_q + 2'd1 : col_idx_q;
    acc_cnt_d  = acc_cnt_q;
    acc_code_d = acc_code_q;
    if (frame_end) begin
      acc_cnt_d  = '0;
      acc_code_d = '0;
    end else if (step) begin
      acc_cnt_d  = frame_cnt;
      acc_code_d = frame_code;
    end
  end

  // Debounce FSM; only a frame-end step can move it. frame_cnt 0 = NONE,
  // 1 = SINGLE(frame_code), 2 = MULTI.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    deb_cnt_d   = deb_cnt_q;
    rel_cnt_d   = rel_cnt_q;
    accept      = 1'b0;
    accept_code = cand_q;
    if (frame_end) begin
      case (state_q)
        IDLE: begin
          if (frame_cnt == 2'd1) begin
            cand_d    = frame_code;
            deb_cnt_d = 4'd1;
            rel_cnt_d = '0;
            if (DEB_LAST == 4'd1) begin
              accept      = 1'b1;
              accept_code = frame_code;
              state_d     = HELD;
            end else begin
              state_d = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (frame_cnt == 2'd1 && frame_code == cand_q) begin
            deb_cnt_d = deb_cnt_q + 4'd1;
            if (deb_cnt_q + 4'd1 == DEB_LAST) begin
              accept    = 1'b1;
              rel_cnt_d = '0;
              state_d   = HELD;
            end
          end else begin
            deb_cnt_d = '0;
            state_d   = IDLE;
          end
        end
        HELD: begin
          if (frame_cnt == 2'd0) begin
            rel_cnt_d = rel_cnt_q + 4'd1;
            if (rel_cnt_q + 4'd1 == DEB_LAST) begin
              rel_cnt_d = '0;
              deb_cnt_d = '0;
              state_d   = IDLE;
            end
          end else begin
            rel_cnt_d = '0;
          end
        end
        default: begin
          state_d   = IDLE;
          deb_cnt_d = '0;
          rel_cnt_d = '0;
        end
      endcase
    end
  end

  // key_valid_o is a single-cycle pulse with no ready/backpressure: a consumer
  // must capture key_code_o/val_o in the cycle key_valid_o is high.
  always_comb begin
    key_valid_d = accept;
    key_code_d  = accept ? accept_code : key_code_q;
    if (clr_i) begin
      val_d = '0;
    end else if (accept) begin
      val_d = {val_q[11:0], accept_code};
    end else begin
      val_d = val_q;
    end
  end

  always_ff @(posedge clk_100MHz_i or posedge rst) begin
    if (rst) begin
      div_q       <= '0;
      col_idx_q   <= '0;
      acc_cnt_q   <= '0;
      acc_code_q  <= '0;
      state_q     <= IDLE;
      cand_q      <= '0;
      deb_cnt_q   <= '0;
      rel_cnt_q   <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= '0;
      val_q       <= '0;
    end else begin
      div_q       <= div_d;
      col_idx_q   <= col_idx_d;
      acc_cnt_q   <= acc_cnt_d;
      acc_code_q  <= acc_code_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      deb_cnt_q   <= deb_cnt_d;
      rel_cnt_q   <= rel_cnt_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      val_q       <= val_d;
    end
  end

  assign key_valid_o = key_valid_q;
  assign key_code_o  = key_code_q;
  assign val_o       = val_q;

endmodule

// File: tb/tb_kbd_scan_4x4.sv
// Bench for kbd_scan_4x4 with SCAN_DIV=4, DEB_FRAMES=3 (16-cycle frames); a
// behavioural keypad closes rows against the driven column.
module tb_kbd_scan_4x4;

  localparam int SCAN_DIV   = 4;
  localparam int DEB_FRAMES = 3;
  localparam int FRAME      = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row_i;
  logic [3:0]  col_o;
  logic        clr_i = 1'b0;
  logic        key_valid_o;
  logic [3:0]  key_code_o;
  logic [15:0] val_o;

  logic [15:0] pressed = '0;  // bit {row, col} = switch closed
  int          cyc;
  int          checks = 0;
  int          passes = 0;
  logic [19:0] exp_q[$];      // {val, code} expected per pulse
  logic [3:0]  exp_col;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d passed %0d", checks, passes);
    $fatal(1, "watchdog");
  end

  kbd_scan_4x4 #(
    .SCAN_DIV   (SCAN_DIV),
    .DEB_FRAMES (DEB_FRAMES)
  ) dut (
    .clk_100MHz_i (clk),
    .rst          (rst),
    .row_i        (row_i),
    .col_o        (col_o),
    .clr_i        (clr_i),
    .key_valid_o  (key_valid_o),
    .key_code_o   (key_code_o),
    .val_o        (val_o)
  );

  // Keypad: a closed switch pulls its row low while its column is driven low.
  always_comb begin
    row_i = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4 + c] && !col_o[c]) row_i[r] = 1'b0;
      end
    end
  end

  // ---------------- check helper ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic hold(input logic [15:0] keys, input int frames);
    pressed = keys;
    repeat (frames * FRAME) @(negedge clk);
  endtask

  task automatic tap(input logic [15:0] keys, input logic [19:0] exp);
    exp_q.push_back(exp);
    hold(keys, 5);
    hold(16'h0000, 4);
  endtask

  task automatic align_frame();
    for (int i = 0; i < FRAME; i++) begin
      if (cyc % FRAME == 0) break;
      @(negedge clk);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (rst === 1'b0 && key_valid_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_pulse: got code %0h val %0h, expected no pulse", key_code_o, val_o);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        check("pulse_code", {28'h0, key_code_o}, {28'h0, e[3:0]});
        check("pulse_val", {16'h0, val_o}, {16'h0, e[19:4]});
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    // 1: reset, then async reset mid-cycle while scanning column 1
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("pre_reset_col", {28'h0, col_o}, 32'hD);
    #2 rst = 1'b1;
    #1;
    check("rst_col", {28'h0, col_o}, 32'hE);
    check("rst_val", {16'h0, val_o}, 32'h0);
    check("rst_valid", {31'h0, key_valid_o}, 32'h0);
    check("rst_code", {28'h0, key_code_o}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= FRAME; i++) begin
      @(negedge clk);
      case ((i / 4) % 4)
        0:       exp_col = 4'b1110;
        1:       exp_col = 4'b1101;
        2:       exp_col = 4'b1011;
        default: exp_col = 4'b0111;
      endcase
      check("col_step", {28'h0, col_o}, {28'h0, exp_col});
    end
    align_frame();

    // 2: r1c2 held 6 frames, released 4 frames
    exp_q.push_back({16'h0006, 4'h6});
    hold(16'h0040, 6);
    hold(16'h0000, 4);
    check("t2_pending", 32'(exp_q.size()), 32'd0);
    check("t2_val", {16'h0, val_o}, 32'h0006);
    check("t2_code", {28'h0, key_code_o}, 32'h6);

    // 3: 1, 2, 3, A, 4
    tap(16'h0001, {16'h0061, 4'h1});
    tap(16'h0002, {16'h0612, 4'h2});
    tap(16'h0004, {16'h6123, 4'h3});
    tap(16'h0008, {16'h123A, 4'hA});
    tap(16'h0010, {16'h23A4, 4'h4});
    check("t3_pending", 32'(exp_q.size()), 32'd0);
    check("t3_val", {16'h0, val_o}, 32'h23A4);

    // 4: bounce on r2c0
    hold(16'h0100, 2);
    hold(16'h0000, 1);
    hold(16'h0100, 2);
    hold(16'h0000, 4);
    check("t4_val", {16'h0, val_o}, 32'h23A4);
    check("t4_code", {28'h0, key_code_o}, 32'h4);

    // 5: two keys together, then key 1 alone
    hold(16'h0003, 6);
    check("t5_multi_val", {16'h0, val_o}, 32'h23A4);
    exp_q.push_back({16'h3A41, 4'h1});
    hold(16'h0001, 5);
    hold(16'h0000, 4);
    check("t5_pending", 32'(exp_q.size()), 32'd0);
    check("t5_val", {16'h0, val_o}, 32'h3A41);

    // 6a: clear, enter 1234, then clear coinciding with the accept of key 9
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
    check("t6_clr_val", {16'h0, val_o}, 32'h0);
    align_frame();
    tap(16'h0001, {16'h0001, 4'h1});
    tap(16'h0002, {16'h0012, 4'h2});
    tap(16'h0004, {16'h0123, 4'h3});
    tap(16'h0010, {16'h1234, 4'h4});
    check("t6_val_1234", {16'h0, val_o}, 32'h1234);
    exp_q.push_back({16'h0000, 4'h9});
    pressed = 16'h0400;
    repeat (3 * FRAME - 1) @(negedge clk);
    clr_i = 1'b1;
    @(negedge clk);
    clr_i = 1'b0;
    check("t6_clr_accept_val", {16'h0, val_o}, 32'h0);
    check("t6_clr_accept_code", {28'h0, key_code_o}, 32'h9);
    hold(16'h0400, 2);
    hold(16'h0000, 4);
    check("t6_pending", 32'(exp_q.size()), 32'd0);

    // 6b: reset during DEBOUNCE of key 5, key kept down only 2 frames after
    pressed = 16'h0020;
    repeat (2 * FRAME + 8) @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_rst_valid", {31'h0, key_valid_o}, 32'h0);
    hold(16'h0020, 2);
    hold(16'h0000, 4);
    check("t6_rst_no_pulse", 32'(exp_q.size()), 32'd0);
    check("t6_rst_val", {16'h0, val_o}, 32'h0);
    tap(16'h0020, {16'h0005, 4'h5});
    check("t6_fresh_val", {16'h0, val_o}, 32'h0005);
    check("final_pending", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
